// File: rtl/cpu_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_ctrl
// Multi-cycle control unit for cpu_v1. It fetches one 32-bit instruction at a
// time over a req/ack port, decodes the RV32I ALU subset (ADD/XOR/OR/AND and
// their immediate forms) and drives the ALU op code, register-file addresses,
// the write strobe and the sign-extended immediate. Any other encoding parks
// the core in HALT until reset.
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst_n        asynchronous active-low reset
//   o_imem_req     fetch request (high only in FETCH)
//   o_imem_addr    byte address of the instruction being fetched (= pc)
//   i_imem_ack     fetch completes, i_imem_data valid this cycle
//   i_imem_data    instruction word
//   o_rf_ra1       rs1 read address (alu src_a)
//   o_rf_ra2       rs2 read address (alu src_b when !o_alu_b_imm)
//   o_rf_wa        rd write address
//   o_rf_we        register write strobe, one-cycle pulse in WB
//   o_alu_op       alu op code: 001 add, 100 xor, 110 or, 111 and
//   o_alu_b_imm    1: src_b = imm, 0: src_b = rs2 data
//   o_imm          sign-extended I-type immediate (instr[31:20])
//   o_pc           current program counter
//   o_halt         core stopped on an illegal instruction
// -----------------------------------------------------------------------------
module cpu_ctrl #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_data,
  output logic [4:0]      o_rf_ra1,
  output logic [4:0]      o_rf_ra2,
  output logic [4:0]      o_rf_wa,
  output logic            o_rf_we,
  output logic [2:0]      o_alu_op,
  output logic            o_alu_b_imm,
  output logic [31:0]     o_imm,
  output logic [PC_W-1:0] o_pc,
  output logic            o_halt
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_imem_req;
  logic            r_rf_we;
  logic            r_halt;
  logic [2:0]      r_alu_op;
  logic            r_alu_b_imm;
  logic [31:0]     r_imm;
  logic [4:0]      r_rf_ra1;
  logic [4:0]      r_rf_ra2;
  logic [4:0]      r_rf_wa;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_f3_ok;
  logic        w_r_type;
  logic        w_i_type;
  logic        w_legal;
  logic [2:0]  w_alu_op;
  logic [31:0] w_imm;

  // Decode fields of the latched instruction. Only consumed in DECODE.
  always_comb begin
    w_opcode = r_instr[6:0];
    w_funct3 = r_instr[14:12];
    w_funct7 = r_instr[31:25];
    w_f3_ok  = (w_funct3 == 3'b000) || (w_funct3 == 3'b100) ||
               (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
    // funct7 must be zero for R-type so SUB/SRA (funct7=0100000) are rejected
    w_r_type = (w_opcode == OPC_OP) && (w_funct7 == 7'b0000000);
    w_i_type = (w_opcode == OPC_OP_IMM);
    w_legal  = (w_r_type || w_i_type) && w_f3_ok;
    // funct3 doubles as the alu code except ADD, which maps 000 -> 001
    w_alu_op = (w_funct3 == 3'b000) ? 3'b001 : w_funct3;
    w_imm    = {{20{r_instr[31]}}, r_instr[31:20]};
  end

  // Single FSM block; every output is a register so nothing glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_imem_req  <= 1'b1;
      r_rf_we     <= 1'b0;
      r_halt      <= 1'b0;
      r_alu_op    <= 3'b000;
      r_alu_b_imm <= 1'b0;
      r_imm       <= '0;
      r_rf_ra1    <= '0;
      r_rf_ra2    <= '0;
      r_rf_wa     <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_rf_we <= 1'b0;
          if (i_imem_ack) begin
            r_instr    <= i_imem_data;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_alu_op    <= w_alu_op;
            r_alu_b_imm <= w_i_type;
            r_imm       <= w_imm;
            r_rf_ra1    <= r_instr[19:15];
            r_rf_ra2    <= r_instr[24:20];
            r_rf_wa     <= r_instr[11:7];
            r_state     <= S_EXEC;
          end else begin
            r_halt  <= 1'b1;
            r_state <= S_HALT;
          end
        end
        S_EXEC: begin
          // x0 is hardwired to zero, so no write strobe for rd=0
          r_rf_we <= (r_rf_wa != 5'd0);
          r_state <= S_WB;
        end
        S_WB: begin
          r_rf_we    <= 1'b0;
          r_pc       <= r_pc + PC_W'(4);
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          r_rf_we    <= 1'b0;
          r_imem_req <= 1'b0;
          r_halt     <= 1'b1;
        end
        default: begin
          r_rf_we    <= 1'b0;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_rf_we     = r_rf_we;
  assign o_halt      = r_halt;
  assign o_alu_op    = r_alu_op;
  assign o_alu_b_imm = r_alu_b_imm;
  assign o_imm       = r_imm;
  assign o_rf_ra1    = r_rf_ra1;
  assign o_rf_ra2    = r_rf_ra2;
  assign o_rf_wa     = r_rf_wa;

endmodule
